encoder_scan: RTL and testbench
===============================

# encoder_scan

Sequential priority encoder: the inverse of the team's 3-to-8 one-hot decoder. Accepts an N-bit request vector over a valid/ready handshake, then emits the index of every set bit, lowest index first, one index per accepted output beat. Sits between request-collection logic and any consumer that needs binary indices, such as a decoder-driven select bus.

## Interface
- N, default 8: request vector width; must be a power of 2 and at least 2.
- IDX_W, default $clog2(N) = 3: index width.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- en  input  1  global enable; low freezes all state and gates both handshakes
- in_valid  input  1  request vector valid
- in  input  N  request vector
- in_ready  output  1  block can accept a vector
- out_valid  output  1  `out` holds a valid index
- out  output  IDX_W  binary index of the lowest pending set bit
- out_ready  input  1  consumer accepts `out`
- out_last  output  1  current index is the final one of this vector
- remaining  output  IDX_W+1  count of pending set bits, 0..N

## Operation
- State machine has two states: IDLE and BUSY. A `pending` register of N bits holds the bits not yet emitted.
- IDLE:
  - in_ready = en.
  - Accept when en & in_valid.
  - If in != 0: pending <= in, then go to BUSY.
  - If in == 0: the vector is consumed and dropped; no output beat; stay in IDLE.
- BUSY:
  - in_ready = 0; out_valid = en.
  - out = index of the lowest set bit of pending.
  - out_last = (pending & (pending - 1)) == 0.
- Pop happens when en & out_valid & out_ready. On pop, the bit at index out is cleared in pending. If out_last, go to IDLE.
- remaining = popcount(pending). It is 0 in IDLE.
- en low:
  - in_ready = 0 and out_valid = 0.
  - pending and state hold.
  - out, out_last and remaining keep reflecting pending.
- Outputs are functions of registered state only. There is no combinational path from in or out_ready to out, out_valid, out_last or remaining.
- No back-to-back overlap: a new vector is accepted only after the cycle in which the last pop occurs.

## Timing
- Reset, asynchronous and taking effect immediately:
  - state = IDLE, pending = 0.
  - out_valid = 0, out = 0, out_last = 0, remaining = 0.
  - in_ready follows en.
- Latency: a vector accepted at edge T gives out_valid = 1 in the cycle after T, with the first index valid.
- Throughput: one index per cycle while out_ready = 1. A vector with k set bits occupies BUSY for k cycles minimum. in_ready returns in the cycle after the last pop.
- Backpressure: while out_valid = 1 and out_ready = 0, out, out_last and remaining are held stable.
- Reset asserted mid-vector: all pending bits are discarded and no further beats are emitted.
- en deasserted mid-vector: emission pauses and resumes at the same index when en returns.

## Structure
- Package encoder_pkg holds:
  - the default N and IDX_W;
  - the state enum (ST_IDLE, ST_BUSY).
- Sub-module pri_enc: combinational, parameterised by N. It takes pending and produces the lowest-set index, a one-hot clear mask and an any-set flag.
- Top level holds the FSM, the pending register, the popcount for remaining, and out_last.

## Test plan
- Reset state: assert rst_n = 0 mid-run with en = 1. Expect out_valid = 0, remaining = 0 and in_ready = 1 immediately, with no clock edge needed.
- Basic scan: in = 8'b1010_0110, out_ready held 1. Expect out = 1, 2, 5, 7 on consecutive cycles; out_last = 1 only with index 7; remaining = 4, 3, 2, 1; in_ready = 1 on the next cycle.
- Backpressure: in = 8'b1000_0001, out_ready = 0 for 3 cycles. Expect out = 0, remaining = 2 and out_valid = 1 held stable. Then release and expect out = 7 with out_last = 1.
- Zero and full vectors:
  - in = 8'h00 is accepted (in_ready = 1 throughout) with no out_valid.
  - in = 8'hFF gives out = 0..7 over 8 cycles, with remaining counting from 8 down to 1.
- Enable and reset mid-vector:
  - With in = 8'b0011_1000, drop en after the first pop. Expect out_valid = 0 and out = 4 held. Raise en and expect indices 4 then 5.
  - Repeat with rst_n pulsed after the first pop. Expect no further beats.
- Randomised cross-check: random vectors and random out_ready. For every vector, the indices emitted must, when re-decoded one-hot and OR-ed together, equal the input vector. Emitted indices must be strictly increasing with exactly one out_last.

Source files
------------

// File: rtl/encoder_pkg.sv
// ---------------------------------------------------------------------------
// encoder_pkg
// Shared definitions for the sequential priority encoder (encoder_scan).
//   ENC_N      : default request vector width (power of 2, >= 2)
//   ENC_IDX_W  : default index width, $clog2(ENC_N)
//   state_e    : scan FSM states
// ---------------------------------------------------------------------------
package encoder_pkg;

   localparam int ENC_N     = 8;
   localparam int ENC_IDX_W = $clog2(ENC_N);

   // IDLE waits for a request vector; BUSY emits one index per pop.
   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } state_e;

endpackage : encoder_pkg

// File: rtl/encoder_scan_pri_enc.sv
// ---------------------------------------------------------------------------
// pri_enc
// Combinational lowest-set-bit priority encoder.
//   pending  [N-1:0]      in  : bits still to be reported
//   idx      [IDX_W-1:0]  out : index of the lowest set bit (0 when none set)
//   clr_mask [N-1:0]      out : one-hot mask selecting that bit (0 when none)
//   any_set               out : at least one bit of pending is set
// ---------------------------------------------------------------------------
module pri_enc #(
   parameter int N     = 8,
   parameter int IDX_W = $clog2(N)
) (
   input  logic [N-1:0]     pending,
   output logic [IDX_W-1:0] idx,
   output logic [N-1:0]     clr_mask,
   output logic             any_set
);

   always_comb begin
      // NOTE: every output gets a default before the loop so that no path
      // leaves one unassigned; otherwise synthesis infers a latch.
      idx      = '0;
      clr_mask = '0;
      any_set  = 1'b0;
      // Scan from the top down so the lowest set bit is the last one written
      // and therefore wins.
      for (int i = N - 1; i >= 0; i--) begin
         if (pending[i]) begin
            idx         = i[IDX_W-1:0];
            clr_mask    = '0;
            clr_mask[i] = 1'b1;
            any_set     = 1'b1;
         end
      end
   end

endmodule : pri_enc

// File: rtl/encoder_scan.sv
// ---------------------------------------------------------------------------
// encoder_scan
// Sequential priority encoder. Accepts an N-bit request vector on a
// valid/ready handshake and emits the index of every set bit, lowest first,
// one index per accepted output beat.
//   clk, rst_n          : rising-edge clock, asynchronous active-low reset
//   en                  : global enable; low freezes state, gates handshakes
//   in_valid/in/in_ready: request vector input handshake
//   out_valid/out/out_ready/out_last : index output handshake, last flag
//   remaining [IDX_W:0] : number of set bits still pending (0..N)
// All outputs derive from registered state (plus en for the handshakes);
// nothing on in or out_ready reaches an output combinationally.
// ---------------------------------------------------------------------------
module encoder_scan
   import encoder_pkg::*;
#(
   parameter int N     = ENC_N,
   parameter int IDX_W = $clog2(N)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             in_valid,
   input  logic [N-1:0]     in,
   output logic             in_ready,
   output logic             out_valid,
   output logic [IDX_W-1:0] out,
   input  logic             out_ready,
   output logic             out_last,
   output logic [IDX_W:0]   remaining
);

   localparam logic [N-1:0] ONE_N = {{(N-1){1'b0}}, 1'b1};

   state_e         state_q, state_d;
   logic [N-1:0]   pending_q, pending_d;

   logic [IDX_W-1:0] low_idx;
   logic [N-1:0]     low_mask;
   logic             any_set;
   logic             pop;

   pri_enc #(
      .N     (N),
      .IDX_W (IDX_W)
   ) u_pri_enc (
      .pending  (pending_q),
      .idx      (low_idx),
      .clr_mask (low_mask),
      .any_set  (any_set)
   );

   // Handshakes are gated by en; the data-side outputs keep reflecting
   // pending so a paused scan resumes at the same index.
   assign in_ready  = en && (state_q == ST_IDLE);
   assign out_valid = en && (state_q == ST_BUSY);
   assign out       = low_idx;
   // A single remaining bit is the last one; any_set keeps out_last low in
   // IDLE, where pending is zero.
   assign out_last  = any_set && ((pending_q & (pending_q - ONE_N)) == '0);
   assign pop       = out_valid && out_ready;

   always_comb begin
      remaining = '0;
      for (int i = 0; i < N; i++) begin
         remaining = remaining + {{IDX_W{1'b0}}, pending_q[i]};
      end
   end

   always_comb begin
      state_d   = state_q;
      pending_d = pending_q;
      unique case (state_q)
         ST_IDLE: begin
            // An all-zero vector is consumed and dropped without a beat.
            if (en && in_valid && (in != '0)) begin
               pending_d = in;
               state_d   = ST_BUSY;
            end
         end
         ST_BUSY: begin
            if (pop) begin
               pending_d = pending_q & ~low_mask;
               if (out_last) begin
                  state_d = ST_IDLE;
               end
            end
         end
         default: begin
            state_d   = ST_IDLE;
            pending_d = '0;
         end
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples its _d value from before the edge, independent of block order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         // NOTE: pending is a plain register that must start empty, so it is
         // reset; a true RAM array would be left unreset and written first.
         pending_q <= '0;
      end else begin
         state_q   <= state_d;
         pending_q <= pending_d;
      end
   end

endmodule : encoder_scan

// File: tb/tb_encoder_scan.sv
// ---------------------------------------------------------------------------
// tb_encoder_scan
// Self-checking bench for encoder_scan (N = 8). Inputs change and outputs are
// sampled on the falling clock edge, away from the active rising edge.
// ---------------------------------------------------------------------------
module tb_encoder_scan;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       en = 1'b1;
   logic       in_valid = 1'b0;
   logic [7:0] in_vec = '0;
   logic       in_ready;
   logic       out_valid;
   logic [2:0] out_idx;
   logic       out_ready = 1'b0;
   logic       out_last;
   logic [3:0] remaining;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   encoder_scan #(.N(8), .IDX_W(3)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .en        (en),
      .in_valid  (in_valid),
      .in        (in_vec),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out       (out_idx),
      .out_ready (out_ready),
      .out_last  (out_last),
      .remaining (remaining)
   );

   // Called at a falling edge. Waits (bounded) for in_ready, presents the
   // vector for one rising edge, and returns at the next falling edge.
   task automatic accept(input logic [7:0] v);
      int t = 0;
      while (!in_ready && t < 50) begin
         @(negedge clk);
         t++;
      end
      n_cmp++;
      if (in_ready !== 1'b1) begin
         $display("FAIL accept_timeout: in_ready=%b required 1", in_ready);
         n_err++;
      end
      in_valid = 1'b1;
      in_vec   = v;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic test_reset();
      // Power-on reset, no clock edge while asserted.
      #1;
      n_cmp++;
      if (out_valid !== 1'b0 || remaining !== 4'd0 || in_ready !== 1'b1 ||
          out_idx !== 3'd0 || out_last !== 1'b0) begin
         $display("FAIL reset_init: valid=%b rem=%0d rdy=%b out=%0d last=%b required 0 0 1 0 0",
                  out_valid, remaining, in_ready, out_idx, out_last);
         n_err++;
      end
      @(negedge clk);
      rst_n = 1'b1;
      out_ready = 1'b1;
      @(negedge clk);
      accept(8'hFF);
      @(posedge clk);               // pops index 0
      #3;
      rst_n = 1'b0;                 // mid-cycle, between edges
      #1;
      n_cmp++;
      if (out_valid !== 1'b0 || remaining !== 4'd0 || in_ready !== 1'b1) begin
         $display("FAIL reset_async: valid=%b rem=%0d rdy=%b required 0 0 1",
                  out_valid, remaining, in_ready);
         n_err++;
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_basic_scan();
      logic [2:0] exp_idx [4] = '{3'd1, 3'd2, 3'd5, 3'd7};
      out_ready = 1'b1;
      accept(8'b1010_0110);
      for (int i = 0; i < 4; i++) begin
         n_cmp++;
         if (out_valid !== 1'b1 || out_idx !== exp_idx[i] ||
             remaining !== 4'(4 - i) || out_last !== (i == 3)) begin
            $display("FAIL basic_beat%0d: valid=%b out=%0d rem=%0d last=%b required 1 %0d %0d %b",
                     i, out_valid, out_idx, remaining, out_last, exp_idx[i], 4 - i, (i == 3));
            n_err++;
         end
         @(posedge clk);
         @(negedge clk);
      end
      n_cmp++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || remaining !== 4'd0) begin
         $display("FAIL basic_done: rdy=%b valid=%b rem=%0d required 1 0 0",
                  in_ready, out_valid, remaining);
         n_err++;
      end
   endtask

   task automatic test_backpressure();
      out_ready = 1'b0;
      accept(8'b1000_0001);
      for (int i = 0; i < 3; i++) begin
         n_cmp++;
         if (out_valid !== 1'b1 || out_idx !== 3'd0 || remaining !== 4'd2 ||
             out_last !== 1'b0) begin
            $display("FAIL bp_hold%0d: valid=%b out=%0d rem=%0d last=%b required 1 0 2 0",
                     i, out_valid, out_idx, remaining, out_last);
            n_err++;
         end
         @(posedge clk);
         @(negedge clk);
      end
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      n_cmp++;
      if (out_valid !== 1'b1 || out_idx !== 3'd7 || out_last !== 1'b1 ||
          remaining !== 4'd1) begin
         $display("FAIL bp_release: valid=%b out=%0d last=%b rem=%0d required 1 7 1 1",
                  out_valid, out_idx, out_last, remaining);
         n_err++;
      end
      @(posedge clk);
      @(negedge clk);
      n_cmp++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         $display("FAIL bp_done: rdy=%b valid=%b required 1 0", in_ready, out_valid);
         n_err++;
      end
   endtask

   task automatic test_zero_full();
      out_ready = 1'b1;
      accept(8'h00);
      for (int i = 0; i < 3; i++) begin
         n_cmp++;
         if (out_valid !== 1'b0 || in_ready !== 1'b1 || remaining !== 4'd0) begin
            $display("FAIL zero_vec%0d: valid=%b rdy=%b rem=%0d required 0 1 0",
                     i, out_valid, in_ready, remaining);
            n_err++;
         end
         @(negedge clk);
      end
      accept(8'hFF);
      for (int i = 0; i < 8; i++) begin
         n_cmp++;
         if (out_valid !== 1'b1 || out_idx !== 3'(i) || remaining !== 4'(8 - i) ||
             out_last !== (i == 7)) begin
            $display("FAIL full_beat%0d: valid=%b out=%0d rem=%0d last=%b required 1 %0d %0d %b",
                     i, out_valid, out_idx, remaining, out_last, i, 8 - i, (i == 7));
            n_err++;
         end
         @(posedge clk);
         @(negedge clk);
      end
      n_cmp++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         $display("FAIL full_done: rdy=%b valid=%b required 1 0", in_ready, out_valid);
         n_err++;
      end
   endtask

   task automatic test_enable_mid();
      out_ready = 1'b1;
      accept(8'b0011_1000);
      n_cmp++;
      if (out_idx !== 3'd3 || remaining !== 4'd3) begin
         $display("FAIL en_first: out=%0d rem=%0d required 3 3", out_idx, remaining);
         n_err++;
      end
      @(posedge clk);               // pops index 3
      @(negedge clk);
      en = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1;
         n_cmp++;
         if (out_valid !== 1'b0 || in_ready !== 1'b0 || out_idx !== 3'd4 ||
             remaining !== 4'd2) begin
            $display("FAIL en_paused%0d: valid=%b rdy=%b out=%0d rem=%0d required 0 0 4 2",
                     i, out_valid, in_ready, out_idx, remaining);
            n_err++;
         end
         @(negedge clk);
      end
      en = 1'b1;
      #1;
      n_cmp++;
      if (out_valid !== 1'b1 || out_idx !== 3'd4 || out_last !== 1'b0) begin
         $display("FAIL en_resume4: valid=%b out=%0d last=%b required 1 4 0",
                  out_valid, out_idx, out_last);
         n_err++;
      end
      @(posedge clk);
      @(negedge clk);
      n_cmp++;
      if (out_valid !== 1'b1 || out_idx !== 3'd5 || out_last !== 1'b1) begin
         $display("FAIL en_resume5: valid=%b out=%0d last=%b required 1 5 1",
                  out_valid, out_idx, out_last);
         n_err++;
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic test_reset_mid();
      out_ready = 1'b1;
      accept(8'b0011_1000);
      @(posedge clk);               // pops index 3
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      n_cmp++;
      if (out_valid !== 1'b0 || remaining !== 4'd0 || out_idx !== 3'd0 ||
          out_last !== 1'b0) begin
         $display("FAIL rstmid_assert: valid=%b rem=%0d out=%0d last=%b required 0 0 0 0",
                  out_valid, remaining, out_idx, out_last);
         n_err++;
      end
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         n_cmp++;
         if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            $display("FAIL rstmid_after%0d: valid=%b rdy=%b required 0 1",
                     i, out_valid, in_ready);
            n_err++;
         end
      end
   endtask

   task automatic test_random();
      for (int n = 0; n < 24; n++) begin
         logic [7:0] v;
         logic [7:0] acc;
         logic [7:0] left;
         int prev;
         int lasts;
         int t;
         int low;
         v     = 8'($urandom_range(0, 255));
         acc   = '0;
         prev  = -1;
         lasts = 0;
         t     = 0;
         out_ready = 1'b1;
         accept(v);
         while (out_valid && t < 300) begin
            left = v & ~acc;
            low  = 0;
            for (int b = 7; b >= 0; b--) if (left[b]) low = b;
            n_cmp++;
            if (out_idx !== 3'(low) || remaining !== 4'($countones(left))) begin
               $display("FAIL rand%0d_state: out=%0d rem=%0d required %0d %0d",
                        n, out_idx, remaining, low, $countones(left));
               n_err++;
            end
            out_ready = 1'($urandom_range(0, 1));
            if (out_ready) begin
               n_cmp++;
               if (int'(out_idx) <= prev) begin
                  $display("FAIL rand%0d_order: out=%0d required > %0d", n, out_idx, prev);
                  n_err++;
               end
               acc[out_idx] = 1'b1;
               prev = int'(out_idx);
               if (out_last) lasts++;
            end
            @(posedge clk);
            @(negedge clk);
            t++;
         end
         n_cmp++;
         if (t >= 300 || acc !== v || lasts != ((v != 8'h00) ? 1 : 0) || in_ready !== 1'b1) begin
            $display("FAIL rand%0d_vector: decoded=%h lasts=%0d rdy=%b cycles=%0d required %h %0d 1",
                     n, acc, lasts, in_ready, t, v, (v != 8'h00) ? 1 : 0);
            n_err++;
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic_scan();
      test_backpressure();
      test_zero_full();
      test_enable_mid();
      test_reset_mid();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule : tb_encoder_scan
